// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with programmable wait states, byte-enabled writes and a sticky illegal-access flag.
// Optional macro AVALON_WAIT_RAM_RANDOM_STALL_EN adds 0..3 LFSR-driven extra stall cycles per transfer.
module avalon_wait_ram #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [32:0] WINDOW = 33'd4 << ADDR_WIDTH;
`ifdef AVALON_WAIT_RAM_RANDOM_STALL_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_load;
    logic [31:0]             r_readdata;
    logic                    r_bus_error;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_req;
    logic [31:0]             w_offset;
    logic                    w_legal;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_to_ack;
    logic                    w_abort;
    logic                    w_commit;

    assign w_req    = read | write;
    assign w_offset = address - BASE_ADDR;
    assign w_idx    = w_offset[ADDR_WIDTH+1:2];
    assign w_legal  = (address[1:0] == 2'b00) && ({1'b0, w_offset} < WINDOW) && !(read && write);

`ifdef AVALON_WAIT_RAM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_load = CNT_W'(WAIT_CYCLES - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_load = CNT_W'(WAIT_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The IDLE cycle in which a request appears is already the first stall cycle,
    // so r_cnt counts the WAIT cycles still to go after the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_load == '0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = w_load - CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!w_req)            w_state_nxt = S_IDLE;
                else if (r_cnt == '0)  w_state_nxt = S_ACK;
                else                   w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        waitrequest = w_req && (r_state != S_ACK);
        w_to_ack    = (r_state != S_ACK) && (w_state_nxt == S_ACK);
        w_abort     = (r_state == S_WAIT) && !w_req;
        w_commit    = (r_state == S_ACK) && write && w_legal;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_to_ack)
                r_readdata <= w_legal ? r_mem[w_idx] : 32'h0;
            if (w_abort || ((r_state == S_ACK) && !w_legal))
                r_bus_error <= 1'b1;
        end
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) r_mem[w_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    assign readdata  = r_readdata;
    assign bus_error = r_bus_error;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: vector table for plain transfers plus hand sequences
// for illegal accesses, aborts, resets mid-transfer, back-to-back and random stalls.
module tb_avalon_wait_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_wait_ram #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'hBFC00000),
        .WAIT_CYCLES(2),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .bus_error  (bus_error)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_stalls(input string name, input int s);
`ifdef AVALON_WAIT_RAM_RANDOM_STALL_EN
        checks++;
        if (s < 2 || s > 5) begin
            failures++;
            $display("FAIL %s stalls actual=%0d required=2..5", name, s);
        end
`else
        chk({name, "_stalls"}, 32'(s), 32'd2);
`endif
    endtask

    // Drives one transfer from an IDLE cycle, returns stall count and readdata at completion.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic [31:0] rdata);
        bit ok;
        read = rd; write = wr; address = addr; writedata = wd; byteenable = be;
        stalls = 0; ok = 1'b0; rdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!waitrequest) begin
                rdata = readdata;
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout addr=%h actual=no_ack required=ack", addr);
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({name, "_rst_readdata"}, readdata, 32'h0);
        chk({name, "_rst_bus_error"}, 32'(bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        logic [31:0] rd;
        logic        wr_seq [6];

        vecs[0] = '{"wr_word0",   1'b0, 1'b1, 32'hBFC00000, 32'h3C021234, 4'hF, 1'b0, 32'h0};
        vecs[1] = '{"rd_word0",   1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 1'b1, 32'h3C021234};
        vecs[2] = '{"wr_word1",   1'b0, 1'b1, 32'hBFC00004, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[3] = '{"wr_be0101",  1'b0, 1'b1, 32'hBFC00004, 32'h11223344, 4'h5, 1'b0, 32'h0};
        vecs[4] = '{"rd_merged",  1'b1, 1'b0, 32'hBFC00004, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vecs[5] = '{"wr_last",    1'b0, 1'b1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vecs[6] = '{"rd_last",    1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'hF, 1'b1, 32'hCAFEF00D};
        vecs[7] = '{"wr_word2",   1'b0, 1'b1, 32'hBFC00008, 32'h55667788, 4'hF, 1'b0, 32'h0};
        vecs[8] = '{"wr_be0",     1'b0, 1'b1, 32'hBFC00008, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
        vecs[9] = '{"rd_word2",   1'b1, 1'b0, 32'hBFC00008, 32'h0,        4'h2, 1'b1, 32'h55667788};

        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_waitrequest_idle", 32'(waitrequest), 32'd0);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        read = 1'b1;
        #1;
        chk("rst_waitrequest_req", 32'(waitrequest), 32'd1);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, s, rd);
            chk_stalls(vecs[i].name, s);
            if (vecs[i].chk_rd) chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_bus_error"}, 32'(bus_error), 32'd0);
        end

        @(negedge clk);
        chk("readdata_hold", readdata, 32'h55667788);
        @(posedge clk); #1;

        // Illegal reads: misaligned, below window, just past window.
        xfer(1'b1, 1'b0, 32'hBFC00002, 32'h0, 4'hF, s, rd);
        chk_stalls("misaligned", s);
        chk("misaligned_data", rd, 32'h0);
        chk("misaligned_err", 32'(bus_error), 32'd1);
        xfer(1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, s, rd);
        chk("sticky_err", 32'(bus_error), 32'd1);
        xfer(1'b1, 1'b0, 32'h00000000, 32'h0, 4'hF, s, rd);
        chk_stalls("below_window", s);
        chk("below_window_data", rd, 32'h0);
        xfer(1'b1, 1'b0, 32'hBFC01000, 32'h0, 4'hF, s, rd);
        chk("past_window_data", rd, 32'h0);
        chk("past_window_err", 32'(bus_error), 32'd1);
        reset_pulse("after_illegal");

        // Out-of-window write must not alias into the RAM.
        xfer(1'b0, 1'b1, 32'hBFC01000, 32'h99999999, 4'hF, s, rd);
        chk("oow_write_err", 32'(bus_error), 32'd1);
        reset_pulse("after_oow_write");
        xfer(1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, s, rd);
        chk("oow_no_alias", rd, 32'h3C021234);

        // Read and write together.
        xfer(1'b1, 1'b1, 32'hBFC00000, 32'h0, 4'hF, s, rd);
        chk_stalls("rw_both", s);
        chk("rw_both_data", rd, 32'h0);
        chk("rw_both_err", 32'(bus_error), 32'd1);
        reset_pulse("after_rw");
        xfer(1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, s, rd);
        chk("rw_ram_unchanged", rd, 32'h3C021234);
        chk("rw_err_cleared", 32'(bus_error), 32'd0);

        // Reset during WAIT of a write.
        read = 1'b0; write = 1'b1; address = 32'hBFC00004;
        writedata = 32'h00000000; byteenable = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_readdata", readdata, 32'h0);
        chk("midrst_bus_error", 32'(bus_error), 32'd0);
        chk("midrst_waitrequest", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, s, rd);
        chk("midrst_old_value", rd, 32'hDE22BE44);

        // Request dropped during WAIT.
        read = 1'b1; address = 32'hBFC00000;
        @(posedge clk); #1;
        read = 1'b0;
        @(negedge clk);
        chk("abort_no_wait", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_err", 32'(bus_error), 32'd1);
        reset_pulse("after_abort");

`ifndef AVALON_WAIT_RAM_RANDOM_STALL_EN
        // Back-to-back: read held through two transfers.
        read = 1'b1; address = 32'hBFC00008; byteenable = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            wr_seq[c] = waitrequest;
            if (c == 2) chk("b2b_data0", readdata, 32'h55667788);
            if (c == 5) chk("b2b_data1", readdata, 32'h55667788);
            @(posedge clk); #1;
        end
        read = 1'b0;
        chk("b2b_waitreq_pattern",
            32'({wr_seq[0], wr_seq[1], wr_seq[2], wr_seq[3], wr_seq[4], wr_seq[5]}),
            32'b110110);
`else
        begin
            logic [31:0] addrs [3];
            logic [31:0] datas [3];
            bit          seen [16];
            int          distinct;
            bit          ok;
            addrs = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
            datas = '{32'h3C021234, 32'hDE22BE44, 32'h55667788};
            for (int k = 0; k < 16; k++) seen[k] = 1'b0;
            read = 1'b1; byteenable = 4'hF;
            for (int t = 0; t < 100; t++) begin
                address = addrs[t % 3];
                s = 0; ok = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (!waitrequest) begin
                        ok = 1'b1;
                        rd = readdata;
                        break;
                    end
                    s++;
                    @(posedge clk); #1;
                end
                chk("rnd_ack", 32'(ok), 32'd1);
                chk_stalls("rnd", s);
                chk("rnd_data", rd, datas[t % 3]);
                if (s < 16) seen[s] = 1'b1;
                @(posedge clk); #1;
            end
            read = 1'b0;
            distinct = 0;
            for (int k = 0; k < 16; k++) if (seen[k]) distinct++;
            checks++;
            if (distinct < 2) begin
                failures++;
                $display("FAIL rnd_distinct actual=%0d required>=2", distinct);
            end
        end
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
